// File: rtl/dma_priority_arbiter.sv
// N-channel DMA request/priority unit with HRQ/HLDA handshake, fixed or rotating
// priority, per-channel release modes and sticky terminal-count status.
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          DREQ,
    input  logic                       HLDA,
    output logic                       HRQ,
    output logic [NUM_CH-1:0]          DACK,
    input  logic                       cmd_disable_i,
    input  logic                       cmd_rot_pri_i,
    input  logic                       cmd_dreq_low_i,
    input  logic                       cmd_dack_high_i,
    input  logic [NUM_CH-1:0]          mask_i,
    input  logic [NUM_CH-1:0]          sw_req_i,
    input  logic [2*NUM_CH-1:0]        mode_i,
    input  logic                       xfer_done_i,
    input  logic                       eop_i,
    input  logic                       status_rd_i,
    output logic                       grant_o,
    output logic [$clog2(NUM_CH)-1:0]  active_ch_o,
    output logic [NUM_CH-1:0]          tc_o,
    output logic [NUM_CH-1:0]          req_o,
    output logic                       abort_o
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_GRANT = 2'd2
    } state_e;

    state_e                               state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]   sync_q, sync_d;
    logic [CH_W-1:0]                      ptr_q, ptr_d;
    logic [CH_W-1:0]                      active_q, active_d;
    logic [NUM_CH-1:0]                    tc_q, tc_d;
    logic [NUM_CH-1:0]                    dack_q, dack_d;
    logic                                 hrq_q, hrq_d;
    logic                                 grant_q, grant_d;
    logic                                 abort_q, abort_d;

    logic [NUM_CH-1:0]                    req;
    logic [CH_W-1:0]                      ptr_eff;
    logic [CH_W-1:0]                      ptr_next;
    logic [CH_W-1:0]                      win_idx;
    logic                                 win_found;
    int unsigned                          cand;
    logic [1:0]                           mode_cur;
    logic                                 req_cur;
    logic                                 rel_xfer;
    logic                                 release_now;

    // DREQ synchroniser shift chain
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = DREQ;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Effective request vector after polarity, mask and software requests
    always_comb begin
        req = ((sync_q[SYNC_STAGES-1] ^ {NUM_CH{cmd_dreq_low_i}}) & ~mask_i) | sw_req_i;
    end

    // Winner search: first requesting channel from the pointer upward, wrapping
    always_comb begin
        ptr_eff   = cmd_rot_pri_i ? ptr_q : '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(ptr_eff) + i) % NUM_CH;
            if (!win_found && req[cand[CH_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Release decode for the channel currently holding the grant
    always_comb begin
        mode_cur = 2'b01;
        req_cur  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (active_q == CH_W'(c)) begin
                mode_cur = mode_i[2*c +: 2];
                req_cur  = req[c];
            end
        end
        unique case (mode_cur)
            2'b00:   rel_xfer = ~req_cur;
            2'b10:   rel_xfer = 1'b0;
            default: rel_xfer = 1'b1;
        endcase
        release_now = eop_i | (xfer_done_i & rel_xfer);
        ptr_next    = (active_q == CH_W'(NUM_CH - 1)) ? '0 : active_q + CH_W'(1);
    end

    // Handshake FSM next state and registered output values
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        ptr_d    = cmd_rot_pri_i ? ptr_q : '0;
        abort_d  = 1'b0;
        tc_d     = tc_q;
        if (status_rd_i) begin
            tc_d = '0;
        end

        unique case (state_q)
            S_IDLE: begin
                active_d = '0;
                if ((|req) && !cmd_disable_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (req == '0) begin
                    state_d = S_IDLE;
                end else if (HLDA && win_found) begin
                    state_d  = S_GRANT;
                    active_d = win_idx;
                end
            end
            S_GRANT: begin
                if (eop_i) begin
                    tc_d[active_q] = 1'b1;
                end
                if (!HLDA) begin
                    state_d  = S_IDLE;
                    active_d = '0;
                    abort_d  = 1'b1;
                end else if (release_now) begin
                    state_d  = S_IDLE;
                    active_d = '0;
                    if (cmd_rot_pri_i) begin
                        ptr_d = ptr_next;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = '0;
            end
        endcase

        hrq_d   = (state_d != S_IDLE);
        grant_d = (state_d == S_GRANT);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dack_d[c] = (grant_d && (active_d == CH_W'(c))) ? cmd_dack_high_i : ~cmd_dack_high_i;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            ptr_q    <= '0;
            active_q <= '0;
            tc_q     <= '0;
            hrq_q    <= 1'b0;
            grant_q  <= 1'b0;
            abort_q  <= 1'b0;
            dack_q   <= {NUM_CH{~cmd_dack_high_i}};
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            tc_q     <= tc_d;
            hrq_q    <= hrq_d;
            grant_q  <= grant_d;
            abort_q  <= abort_d;
            dack_q   <= dack_d;
        end
    end

    assign HRQ         = hrq_q;
    assign DACK        = dack_q;
    assign grant_o     = grant_q;
    assign active_ch_o = active_q;
    assign tc_o        = tc_q;
    assign req_o       = req;
    assign abort_o     = abort_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter (4 channels, 2 sync stages).
module tb_dma_priority_arbiter;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  DREQ;
    logic        HLDA;
    logic        HRQ;
    logic [3:0]  DACK;
    logic        cmd_disable_i, cmd_rot_pri_i, cmd_dreq_low_i, cmd_dack_high_i;
    logic [3:0]  mask_i, sw_req_i;
    logic [7:0]  mode_i;
    logic        xfer_done_i, eop_i, status_rd_i;
    logic        grant_o;
    logic [1:0]  active_ch_o;
    logic [3:0]  tc_o, req_o;
    logic        abort_o;

    int checks   = 0;
    int failures = 0;
    int unsigned m_ptr = 0;
    logic [3:0]  m_tc  = 4'b0000;

    always #5 CLK = ~CLK;

    dma_priority_arbiter #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .HRQ(HRQ), .DACK(DACK),
        .cmd_disable_i(cmd_disable_i), .cmd_rot_pri_i(cmd_rot_pri_i),
        .cmd_dreq_low_i(cmd_dreq_low_i), .cmd_dack_high_i(cmd_dack_high_i),
        .mask_i(mask_i), .sw_req_i(sw_req_i), .mode_i(mode_i),
        .xfer_done_i(xfer_done_i), .eop_i(eop_i), .status_rd_i(status_rd_i),
        .grant_o(grant_o), .active_ch_o(active_ch_o), .tc_o(tc_o), .req_o(req_o),
        .abort_o(abort_o)
    );

    // Reference: effective request from the request rules
    function automatic logic [3:0] model_req(logic [3:0] d, logic [3:0] m, logic [3:0] s, logic low);
        return ((d ^ {4{low}}) & ~m) | s;
    endfunction

    // Reference: rotate the request vector down by the pointer and take its lowest set bit
    function automatic int model_winner(logic [3:0] r, int unsigned p);
        logic [7:0] dbl;
        logic [7:0] sh;
        dbl = {r, r};
        sh  = dbl >> p;
        for (int k = 0; k < 4; k++) begin
            if (sh[k]) return int'((p + k) % 4);
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        DREQ = 4'b0; sw_req_i = 4'b0; mask_i = 4'b0; HLDA = 1'b0;
        xfer_done_i = 1'b0; eop_i = 1'b0; status_rd_i = 1'b0;
        repeat (6) tick();
    endtask

    // Wait (bounded) for HRQ, answer with HLDA and report the granted channel
    task automatic do_grant(output int ch, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        ch = -1;
        while (HRQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (HRQ !== 1'b1) begin
            failures++;
            $display("FAIL hrq_timeout: HRQ=%b required 1", HRQ);
            return;
        end
        HLDA = 1'b1;
        tick();
        checks++;
        if (grant_o !== 1'b1) begin
            failures++;
            $display("FAIL grant_up: grant_o=%b required 1", grant_o);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (DACK[k] === 1'b1) ch = k;
        end
        ok = 1'b1;
    endtask

    task automatic pulse_release(input bit use_eop);
        if (use_eop) eop_i = 1'b1; else xfer_done_i = 1'b1;
        tick();
        eop_i = 1'b0; xfer_done_i = 1'b0; HLDA = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; cmd_dack_high_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (DACK !== 4'hF) begin
            failures++; $display("FAIL reset_dack_low: DACK=%b required 1111", DACK);
        end
        cmd_dack_high_i = 1'b1;
        tick();
        checks++;
        if ({HRQ, DACK, grant_o, active_ch_o, tc_o, abort_o, req_o} !== 15'b0) begin
            failures++;
            $display("FAIL reset_state: HRQ=%b DACK=%b grant=%b act=%0d tc=%b abort=%b req=%b required all 0",
                     HRQ, DACK, grant_o, active_ch_o, tc_o, abort_o, req_o);
        end
        RESET = 1'b1;
        settle();
    endtask

    task automatic test_fixed_timing();
        DREQ = 4'b0110;
        tick();
        checks++;
        if (req_o !== 4'b0000) begin
            failures++; $display("FAIL sync_early: req_o=%b required 0000", req_o);
        end
        tick();
        checks++;
        if (req_o !== 4'b0110 || HRQ !== 1'b0) begin
            failures++; $display("FAIL sync_latency: req_o=%b HRQ=%b required 0110/0", req_o, HRQ);
        end
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            failures++; $display("FAIL hrq_latency: HRQ=%b required 1", HRQ);
        end
        repeat (2) tick();
        HLDA = 1'b1;
        tick();
        checks++;
        if (DACK !== 4'b0010 || active_ch_o !== 2'd1 || grant_o !== 1'b1) begin
            failures++; $display("FAIL fixed_grant: DACK=%b act=%0d grant=%b required 0010/1/1", DACK, active_ch_o, grant_o);
        end
        pulse_release(1'b0);
        checks++;
        if (grant_o !== 1'b0 || HRQ !== 1'b0 || DACK !== 4'b0) begin
            failures++; $display("FAIL single_release: grant=%b HRQ=%b DACK=%b required 0/0/0000", grant_o, HRQ, DACK);
        end
        settle();
    endtask

    task automatic test_rotating();
        int ch;
        bit ok;
        int exp;
        cmd_rot_pri_i = 1'b1; m_ptr = 0; DREQ = 4'hF;
        for (int g = 0; g < 5; g++) begin
            do_grant(ch, ok);
            if (ok) begin
                exp = model_winner(4'hF, m_ptr);
                checks++;
                if (ch != exp || int'(active_ch_o) != exp) begin
                    failures++; $display("FAIL rot_order[%0d]: ch=%0d act=%0d required %0d", g, ch, active_ch_o, exp);
                end
                pulse_release(1'b0);
                m_ptr = (m_ptr + 1 + (exp - int'(m_ptr))) % 4;
                checks++;
                if (HRQ !== 1'b0 || grant_o !== 1'b0) begin
                    failures++; $display("FAIL rot_gap[%0d]: HRQ=%b grant=%b required 0/0", g, HRQ, grant_o);
                end
            end
        end
        cmd_rot_pri_i = 1'b0; m_ptr = 0;
        settle();
    endtask

    task automatic test_block_tc();
        int ch;
        bit ok;
        mode_i = 8'b01_10_01_01; DREQ = 4'b0100;
        do_grant(ch, ok);
        for (int p = 0; p < 5; p++) begin
            xfer_done_i = 1'b1;
            tick();
            xfer_done_i = 1'b0;
            checks++;
            if ({grant_o, DACK} !== 5'b1_0100) begin
                failures++; $display("FAIL block_hold[%0d]: grant=%b DACK=%b required 1/0100", p, grant_o, DACK);
            end
            tick();
        end
        eop_i = 1'b1; status_rd_i = 1'b1;
        tick();
        eop_i = 1'b0; status_rd_i = 1'b0; HLDA = 1'b0;
        checks++;
        if (grant_o !== 1'b0 || tc_o !== 4'b0100) begin
            failures++; $display("FAIL block_eop_tc: grant=%b tc=%b required 0/0100", grant_o, tc_o);
        end
        status_rd_i = 1'b1;
        tick();
        status_rd_i = 1'b0;
        checks++;
        if (tc_o !== 4'b0000) begin
            failures++; $display("FAIL tc_clear: tc=%b required 0000", tc_o);
        end
        mode_i = 8'b01_01_01_01;
        settle();
    endtask

    task automatic test_demand();
        int ch;
        bit ok;
        mode_i = 8'b01_01_01_00; DREQ = 4'b0001;
        do_grant(ch, ok);
        xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        checks++;
        if (grant_o !== 1'b1 || DACK !== 4'b0001) begin
            failures++; $display("FAIL demand_hold: grant=%b DACK=%b required 1/0001", grant_o, DACK);
        end
        DREQ = 4'b0000;
        repeat (3) tick();
        checks++;
        if (grant_o !== 1'b1 || req_o !== 4'b0000) begin
            failures++; $display("FAIL demand_idle_hold: grant=%b req=%b required 1/0000", grant_o, req_o);
        end
        pulse_release(1'b0);
        checks++;
        if (grant_o !== 1'b0 || HRQ !== 1'b0) begin
            failures++; $display("FAIL demand_release: grant=%b HRQ=%b required 0/0", grant_o, HRQ);
        end
        mode_i = 8'b01_01_01_01;
        settle();
    endtask

    task automatic test_abort();
        int ch;
        bit ok;
        DREQ = 4'b0010;
        do_grant(ch, ok);
        HLDA = 1'b0;
        tick();
        checks++;
        if (abort_o !== 1'b1 || HRQ !== 1'b0 || DACK !== 4'b0 || grant_o !== 1'b0) begin
            failures++; $display("FAIL abort_edge: abort=%b HRQ=%b DACK=%b grant=%b required 1/0/0000/0", abort_o, HRQ, DACK, grant_o);
        end
        tick();
        checks++;
        if (abort_o !== 1'b0) begin
            failures++; $display("FAIL abort_pulse: abort=%b required 0", abort_o);
        end
        settle();
    endtask

    task automatic test_mask_sw_reset();
        int ch;
        bit ok;
        bit seen;
        seen = 1'b0;
        mask_i = 4'hF; DREQ = 4'hF;
        repeat (6) begin
            tick();
            if (HRQ !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || req_o !== 4'b0) begin
            failures++; $display("FAIL masked_no_hrq: hrq_seen=%b req=%b required 0/0000", seen, req_o);
        end
        sw_req_i = 4'b1000;
        #1;
        checks++;
        if (req_o !== 4'b1000) begin
            failures++; $display("FAIL sw_req_comb: req=%b required 1000", req_o);
        end
        do_grant(ch, ok);
        checks++;
        if (ch != 3 || DACK !== 4'b1000) begin
            failures++; $display("FAIL sw_grant: ch=%0d DACK=%b required 3/1000", ch, DACK);
        end
        RESET = 1'b0;
        tick();
        checks++;
        if ({HRQ, DACK, grant_o, active_ch_o, abort_o, tc_o} !== 13'b0) begin
            failures++; $display("FAIL reset_mid_grant: HRQ=%b DACK=%b grant=%b act=%0d abort=%b tc=%b required all 0",
                                 HRQ, DACK, grant_o, active_ch_o, abort_o, tc_o);
        end
        RESET = 1'b1;
        m_ptr = 0;
        settle();
    endtask

    task automatic test_random();
        int ch;
        bit ok;
        int exp;
        bit use_eop;
        logic [3:0] exp_req;
        status_rd_i = 1'b1;
        tick();
        status_rd_i = 1'b0;
        m_tc = 4'b0;
        for (int it = 0; it < 24; it++) begin
            cmd_rot_pri_i = 1'($urandom_range(0, 1));
            if (!cmd_rot_pri_i) m_ptr = 0;
            DREQ   = 4'($urandom);
            mask_i = 4'($urandom);
            sw_req_i = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            for (int c = 0; c < 4; c++) mode_i[2*c +: 2] = 2'($urandom_range(1, 3));
            repeat (3) tick();
            exp_req = model_req(DREQ, mask_i, sw_req_i, 1'b0);
            checks++;
            if (req_o !== exp_req) begin
                failures++; $display("FAIL rnd_req[%0d]: req=%b required %b", it, req_o, exp_req);
            end
            if (exp_req == 4'b0) begin
                checks++;
                if (HRQ !== 1'b0) begin
                    failures++; $display("FAIL rnd_no_hrq[%0d]: HRQ=%b required 0", it, HRQ);
                end
            end else begin
                do_grant(ch, ok);
                if (ok) begin
                    exp = model_winner(exp_req, m_ptr);
                    checks++;
                    if (ch != exp) begin
                        failures++; $display("FAIL rnd_winner[%0d]: ch=%0d required %0d (req=%b ptr=%0d)", it, ch, exp, exp_req, m_ptr);
                    end
                    use_eop = (mode_i[2*exp +: 2] == 2'b10) || ($urandom_range(0, 1) == 1);
                    pulse_release(use_eop);
                    if (use_eop) m_tc[exp] = 1'b1;
                    m_ptr = cmd_rot_pri_i ? unsigned'((exp + 1) % 4) : 0;
                    checks++;
                    if (grant_o !== 1'b0 || tc_o !== m_tc) begin
                        failures++; $display("FAIL rnd_release[%0d]: grant=%b tc=%b required 0/%b", it, grant_o, tc_o, m_tc);
                    end
                end
            end
            settle();
        end
        cmd_rot_pri_i = 1'b0; m_ptr = 0;
    endtask

    initial begin
        RESET = 1'b0; DREQ = 4'b0; HLDA = 1'b0;
        cmd_disable_i = 1'b0; cmd_rot_pri_i = 1'b0; cmd_dreq_low_i = 1'b0; cmd_dack_high_i = 1'b1;
        mask_i = 4'b0; sw_req_i = 4'b0; mode_i = 8'b01_01_01_01;
        xfer_done_i = 1'b0; eop_i = 1'b0; status_rd_i = 1'b0;
        tick();
        test_reset();
        test_fixed_timing();
        test_rotating();
        test_block_tc();
        test_demand();
        test_abort();
        test_mask_sw_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
